dtree_vote_accum: RTL and testbench

- Downstream stage of the pendigits decision-tree classifier.
- Consumes the tree's 4-bit class prediction once per valid feature sample and accumulates per-class votes over a fixed window of samples.
- At the end of each window it emits the majority class, the winning vote count and the reject count through a valid/ready handshake.
- Smooths per-sample tree decisions into one decision per pen stroke window.

---
 rtl/dtree_pkg.sv | 19 +
 rtl/dtree_argmax_scan.sv | 61 ++++++
 rtl/dtree_vote_accum.sv | 104 ++++++++++
 tb/tb_dtree_vote_accum.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtree_pkg.sv
// Shared types and helpers for the decision-tree vote accumulator.
// Pure declarations: no latency and no flow control of their own.
package dtree_pkg;

  localparam int CLASS_W = 4;
  localparam logic [CLASS_W-1:0] NO_CLASS = 4'hF;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    OUT   = 2'd2
  } state_t;

  function automatic logic is_legal_class(input logic [CLASS_W-1:0] code,
                                          input int num_classes);
    return int'({28'd0, code}) < num_classes;
  endfunction

endpackage

// File: rtl/dtree_argmax_scan.sv
// Sequential argmax over the class counters, one class per cycle, lowest index wins ties.
// done pulses NUM_CLASSES cycles after start; no backpressure, caller holds counts stable.
module dtree_argmax_scan
  import dtree_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int CNT_W       = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [NUM_CLASSES-1:0][CNT_W-1:0] counts,
  output logic                              done,
  output logic [CLASS_W-1:0]                best_idx,
  output logic [CNT_W-1:0]                  best_cnt
);

  localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(NUM_CLASSES - 1);

  logic                busy;
  logic [CLASS_W-1:0]  idx;
  logic [CNT_W-1:0]    cur_cnt;

  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (idx == CLASS_W'(i)) cur_cnt = counts[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      idx      <= '0;
      done     <= 1'b0;
      best_idx <= NO_CLASS;
      best_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy     <= 1'b1;
        idx      <= '0;
        best_idx <= NO_CLASS;
        best_cnt <= '0;
      end else if (busy) begin
        // strict compare keeps the earlier (lower) index on a tie
        if (cur_cnt > best_cnt) begin
          best_cnt <= cur_cnt;
          best_idx <= idx;
        end
        if (idx == LAST_IDX) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          idx <= idx + CLASS_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/dtree_vote_accum.sv
// Accumulates per-class votes over WINDOW samples and emits the majority class; result valid
// NUM_CLASSES+1 cycles after the last accept; in_ready low from window end until out handshake.
module dtree_vote_accum
  import dtree_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int WINDOW      = 8,
  parameter int CNT_W       = $clog2(WINDOW + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CLASS_W-1:0] in_class,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [CLASS_W-1:0] out_class,
  output logic [CNT_W-1:0]   out_votes,
  output logic [CNT_W-1:0]   out_rejects,
  output logic               out_novote,
  output logic               out_valid,
  input  logic               out_ready
);

  state_t state, state_nxt;

  logic [NUM_CLASSES-1:0][CNT_W-1:0] class_cnt;
  logic [CNT_W-1:0]                  rej_cnt;
  logic [CNT_W-1:0]                  smp_cnt;

  logic               accept;
  logic               last_smp;
  logic               handshake;
  logic               legal;
  logic               novote;
  logic               scan_done;
  logic [CLASS_W-1:0] scan_idx;
  logic [CNT_W-1:0]   scan_cnt;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == OUT);
  assign accept    = in_valid && in_ready;
  assign last_smp  = accept && (smp_cnt == CNT_W'(WINDOW - 1));
  assign handshake = out_valid && out_ready;
  assign legal     = is_legal_class(in_class, NUM_CLASSES);
  assign novote    = (rej_cnt == CNT_W'(WINDOW));

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACCUM:   if (last_smp)  state_nxt = SCAN;
      SCAN:    if (scan_done) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // counters stay frozen through SCAN/OUT so the scan reads a stable snapshot
  always_ff @(posedge clk) begin
    if (rst || handshake) begin
      class_cnt <= '0;
      rej_cnt   <= '0;
      smp_cnt   <= '0;
    end else if (accept) begin
      smp_cnt <= last_smp ? '0 : smp_cnt + CNT_W'(1);
      if (!legal) rej_cnt <= rej_cnt + CNT_W'(1);
      for (int i = 0; i < NUM_CLASSES; i++) begin
        if (legal && (in_class == CLASS_W'(i)))
          class_cnt[i] <= class_cnt[i] + CNT_W'(1);
      end
    end
  end

  dtree_argmax_scan #(
    .NUM_CLASSES (NUM_CLASSES),
    .CNT_W       (CNT_W)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .start    (last_smp),
    .counts   (class_cnt),
    .done     (scan_done),
    .best_idx (scan_idx),
    .best_cnt (scan_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_class   <= NO_CLASS;
      out_votes   <= '0;
      out_rejects <= '0;
      out_novote  <= 1'b0;
    end else if ((state == SCAN) && scan_done) begin
      out_class   <= novote ? NO_CLASS : scan_idx;
      out_votes   <= novote ? '0 : scan_cnt;
      out_rejects <= rej_cnt;
      out_novote  <= novote;
    end
  end

endmodule

// File: tb/tb_dtree_vote_accum.sv
// Randomized and directed bench for dtree_vote_accum against a window-level vote model.
// The model counts votes per window with plain arithmetic and predicts result timing.
module tb_dtree_vote_accum;

  localparam int NC  = 10;
  localparam int WIN = 8;
  localparam int CW  = $clog2(WIN + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    in_class;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    out_class;
  logic [CW-1:0] out_votes;
  logic [CW-1:0] out_rejects;
  logic          out_novote;
  logic          out_valid;
  logic          out_ready;

  dtree_vote_accum #(.NUM_CLASSES(NC), .WINDOW(WIN)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_class    (in_class),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_class   (out_class),
    .out_votes   (out_votes),
    .out_rejects (out_rejects),
    .out_novote  (out_novote),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // window model state
  logic [3:0] win[$];
  bit         busy      = 0;
  bit         exp_valid = 0;
  int         cd        = 0;
  bit         accepted  = 0;
  int         n_results = 0;
  logic [3:0] e_class;
  int         e_votes;
  int         e_rej;
  bit         e_novote;
  logic [3:0] pat[8];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // majority = smallest legal class holding the maximum count; no legal votes -> 4'hF
  task automatic predict();
    int cnt[16];
    int m;
    for (int c = 0; c < 16; c++) cnt[c] = 0;
    e_rej = 0;
    foreach (win[k]) begin
      if (win[k] < NC) cnt[win[k]]++;
      else e_rej++;
    end
    m = 0;
    for (int c = 0; c < NC; c++) m = (cnt[c] > m) ? cnt[c] : m;
    e_class = 4'hF;
    e_votes = m;
    if (m > 0) begin
      for (int c = NC - 1; c >= 0; c--) if (cnt[c] == m) e_class = 4'(c);
    end
    e_novote = (e_rej == WIN);
  endtask

  task automatic tick();
    bit acc, ho;
    chk("in_ready", 32'(in_ready), 32'(!busy));
    acc = in_valid && !busy && !rst;
    ho  = exp_valid && out_ready && !rst;
    @(posedge clk);
    accepted = acc;
    if (rst) begin
      win.delete();
      busy      = 0;
      exp_valid = 0;
      cd        = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) exp_valid = 1;
      end
      if (acc) begin
        win.push_back(in_class);
        if (win.size() == WIN) begin
          busy = 1;
          cd   = NC + 1;
          predict();
        end
      end
      if (ho) begin
        exp_valid = 0;
        busy      = 0;
        win.delete();
        n_results++;
      end
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("out_class",   32'(out_class),   32'(e_class));
      chk("out_votes",   32'(out_votes),   32'(e_votes));
      chk("out_rejects", 32'(out_rejects), 32'(e_rej));
      chk("out_novote",  32'(out_novote),  32'(e_novote));
    end
  endtask

  task automatic send(input logic [3:0] v, input int gap);
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_class = v;
    accepted = 0;
    for (int k = 0; k < 200 && !accepted; k++) tick();
    if (!accepted) chk("accept_timeout", 32'(accepted), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (!out_valid) chk("result_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic run_window(input int gap);
    int n;
    for (int k = 0; k < WIN; k++) send(pat[k], gap);
    wait_result(n);
  endtask

  task automatic consume(input int stall, input bit offer7);
    out_ready = 1'b0;
    if (offer7) begin
      in_valid = 1'b1;
      in_class = 4'd7;
    end
    repeat (stall) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_class  = 4'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid",   32'(out_valid),   32'd0);
    chk("rst_class",   32'(out_class),   32'hF);
    chk("rst_votes",   32'(out_votes),   32'd0);
    chk("rst_rejects", 32'(out_rejects), 32'd0);
    chk("rst_novote",  32'(out_novote),  32'd0);
    chk("rst_ready",   32'(in_ready),    32'd1);

    // basic majority plus exact result latency
    pat = '{4'd3, 4'd3, 4'd5, 4'd3, 4'd7, 4'd5, 4'd3, 4'd1};
    for (int k = 0; k < WIN; k++) send(pat[k], 0);
    wait_result(n);
    chk("t1_latency", 32'(n), 32'(NC + 1));
    chk("t1_class",   32'(out_class),   32'd3);
    chk("t1_votes",   32'(out_votes),   32'd4);
    chk("t1_rejects", 32'(out_rejects), 32'd0);
    chk("t1_novote",  32'(out_novote),  32'd0);
    consume(0, 0);

    // tie resolves to lowest index
    pat = '{4'd2, 4'd2, 4'd6, 4'd6, 4'd1, 4'd9, 4'd9, 4'd0};
    run_window(0);
    chk("tie_class", 32'(out_class), 32'd2);
    chk("tie_votes", 32'(out_votes), 32'd2);
    consume(1, 0);

    // rejects, then an all-reject window
    pat = '{4'd12, 4'd15, 4'd4, 4'd10, 4'd11, 4'd4, 4'd13, 4'd14};
    run_window(0);
    chk("rej_class",   32'(out_class),   32'd4);
    chk("rej_votes",   32'(out_votes),   32'd2);
    chk("rej_rejects", 32'(out_rejects), 32'd6);
    consume(0, 0);
    for (int k = 0; k < WIN; k++) pat[k] = 4'd15;
    run_window(0);
    chk("nov_class",   32'(out_class),   32'hF);
    chk("nov_votes",   32'(out_votes),   32'd0);
    chk("nov_rejects", 32'(out_rejects), 32'd8);
    chk("nov_novote",  32'(out_novote),  32'd1);

    // backpressure: a 7 offered during the stall must land only in the next window
    consume(20, 1);
    tick();
    chk("bp_accept7", 32'(accepted), 32'd1);
    in_valid = 1'b0;
    pat = '{4'd7, 4'd7, 4'd7, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0};
    for (int k = 0; k < WIN - 1; k++) send(pat[k], 0);
    wait_result(n);
    chk("bp_class", 32'(out_class), 32'd1);
    chk("bp_votes", 32'(out_votes), 32'd4);
    consume(2, 0);

    // reset mid-window leaves no residue
    for (int k = 0; k < 5; k++) send(4'd8, 0);
    pulse_rst();
    for (int k = 0; k < WIN; k++) pat[k] = 4'd1;
    run_window(0);
    chk("mrst_class", 32'(out_class), 32'd1);
    chk("mrst_votes", 32'(out_votes), 32'd8);
    consume(0, 0);

    // reset during SCAN, then during OUT
    for (int k = 0; k < WIN; k++) send(4'd2, 0);
    repeat (3) tick();
    pulse_rst();
    chk("scan_rst_valid", 32'(out_valid), 32'd0);
    repeat (15) tick();
    run_window(0);
    pulse_rst();
    chk("out_rst_valid", 32'(out_valid), 32'd0);
    repeat (3) tick();

    // gapped input: valid toggles every cycle
    base = n_results;
    for (int k = 0; k < WIN; k++) pat[k] = 4'd0;
    run_window(1);
    chk("gap_class", 32'(out_class), 32'd0);
    chk("gap_votes", 32'(out_votes), 32'd8);
    consume(0, 0);
    repeat (20) tick();
    chk("gap_results", 32'(n_results - base), 32'd1);

    // randomized windows with occasional mid-window reset
    for (int w = 0; w < 14; w++) begin
      if ($urandom_range(0, 5) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, WIN - 1)); k++)
          send(4'($urandom_range(0, 15)), 0);
        pulse_rst();
      end
      for (int k = 0; k < WIN; k++) begin
        if ($urandom_range(0, 3) == 0) pat[k] = 4'($urandom_range(NC, 15));
        else                           pat[k] = 4'($urandom_range(0, 4));
      end
      run_window(int'($urandom_range(0, 2)));
      consume(int'($urandom_range(0, 5)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
